// File: rtl/alu_logic_pkg.sv
// Shared constants for the logic-gate ALU slice.
// Opcodes and controller FSM encoding.
package alu_logic_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOT     = 3'd0;
  localparam logic [OP_W-1:0] OP_AND     = 3'd1;
  localparam logic [OP_W-1:0] OP_OR      = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND    = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR     = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR     = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR    = 3'd6;
  localparam logic [OP_W-1:0] OP_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nbit_logic_bank.sv
// Bank of n-bit bitwise gates with an opcode-selected output.
// Purely combinational; illegal opcodes yield zero plus err.
module nbit_logic_bank
  import alu_logic_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  logic [WIDTH-1:0] w_not;
  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] w_nand;
  logic [WIDTH-1:0] w_nor;
  logic [WIDTH-1:0] w_xor;
  logic [WIDTH-1:0] w_xnor;

  assign w_not  = ~a;
  assign w_and  = a & b;
  assign w_or   = a | b;
  assign w_nand = ~(a & b);
  assign w_nor  = ~(a | b);
  assign w_xor  = a ^ b;
  assign w_xnor = ~(a ^ b);

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      OP_NOT:  result = w_not;
      OP_AND:  result = w_and;
      OP_OR:   result = w_or;
      OP_NAND: result = w_nand;
      OP_NOR:  result = w_nor;
      OP_XOR:  result = w_xor;
      OP_XNOR: result = w_xnor;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_logic_ctrl.sv
// Command sequencer for the logic gate bank: accept, execute,
// then hold a registered result until the consumer takes it.
module alu_logic_ctrl
  import alu_logic_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_err,
  output logic [CNT_W-1:0] op_count
);

  state_t           r_state;
  state_t           w_next;
  logic [OP_W-1:0]  r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ones;
  logic             r_err;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_res;
  logic             w_err;

  nbit_logic_bank #(.WIDTH(WIDTH)) u_bank (
    .a      (r_a),
    .b      (r_b),
    .op     (r_op),
    .result (w_res),
    .err    (w_err)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_next = ST_EXEC;
      ST_EXEC: w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ones   <= 1'b0;
      r_err    <= 1'b0;
      r_valid  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      r_valid <= (w_next == ST_DONE);
      if (r_state == ST_IDLE && in_valid) begin
        r_op <= in_op;
        r_a  <= in_a;
        r_b  <= in_b;
      end
      // Errored ops never report all-ones, even at WIDTH where 0 could alias.
      if (r_state == ST_EXEC) begin
        r_result <= w_res;
        r_zero   <= (w_res == '0);
        r_ones   <= !w_err && (w_res == {WIDTH{1'b1}});
        r_err    <= w_err;
      end
      if (r_state == ST_DONE && out_ready)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = r_valid;
  assign out_result = r_result;
  assign out_zero   = r_zero;
  assign out_ones   = r_ones;
  assign out_err    = r_err;
  assign op_count   = r_cnt;

endmodule
